// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 normalize/round back end.
package fma16_pkg;

  localparam int          BIAS    = 15;
  localparam logic [4:0]  EXP_MAX = 5'h1F;
  localparam logic [14:0] MAXFIN  = 15'h7BFF;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RM  = 2'b10,
    RP  = 2'b11
  } rmode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/fma16_round_pack.sv
// Combinational rounding, overflow/underflow selection and fp16 packing of a
// normalized (or subnormal-aligned) 23-bit magnitude.
module fma16_round_pack #(
  parameter int BIAS = 15
) (
  input  logic              [22:0] sum,
  input  logic                     sign,
  input  logic signed       [7:0]  exp,
  input  logic                     sticky,
  input  fma16_pkg::rmode_t        roundmode,
  output logic              [15:0] result,
  output logic              [2:0]  flags
);
  import fma16_pkg::*;

  localparam logic signed [8:0] EXP_OVF = 9'(2 * BIAS + 1);

  logic              int_bit;
  logic [9:0]        frac;
  logic              g;
  logic              t;
  logic              l;
  logic              inexact;
  logic              inc;
  logic              to_inf;
  logic [11:0]       rnd;
  logic              int_r;
  logic [9:0]        frac_r;
  logic signed [8:0] exp_w;
  logic signed [8:0] exp_r;
  logic              ovf;

  always_comb begin
    int_bit = sum[21];
    frac    = sum[20:11];
    g       = sum[10];
    t       = (|sum[9:0]) | sticky;
    l       = sum[11];
    inexact = g | t;

    case (roundmode)
      RNE:     inc = g & (t | l);
      RP:      inc = ~sign & inexact;
      RM:      inc = sign & inexact;
      default: inc = 1'b0;
    endcase

    case (roundmode)
      RNE:     to_inf = 1'b1;
      RP:      to_inf = ~sign;
      RM:      to_inf = sign;
      default: to_inf = 1'b0;
    endcase

    // A subnormal rounding up to 1.0 lands naturally in int_r with exp == 1.
    rnd   = {1'b0, int_bit, frac} + 12'(inc);
    exp_w = {exp[7], exp};
    if (rnd[11]) begin
      int_r  = 1'b1;
      frac_r = 10'h000;
      exp_r  = exp_w + 9'sd1;
    end else begin
      int_r  = rnd[10];
      frac_r = rnd[9:0];
      exp_r  = exp_w;
    end

    ovf = int_r & (exp_r >= EXP_OVF);

    if (ovf) begin
      result = to_inf ? {sign, EXP_MAX, 10'h000} : {sign, MAXFIN};
    end else begin
      result = {sign, (int_r ? exp_r[4:0] : 5'h00), frac_r};
    end

    flags = {ovf, inexact & ~int_bit, ovf | inexact};
  end

endmodule

// File: rtl/fma16_normround_seq.sv
// Post-add back end of the fma16 datapath: one-bit-per-cycle normalization,
// then a single rounding cycle, with valid/ready on both sides.
module fma16_normround_seq #(
  parameter int SUM_W = 23,
  parameter int BIAS  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  input  logic             sign,
  input  logic [6:0]       exp,
  input  logic             sticky,
  input  logic [1:0]       roundmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic [2:0]       flags
);
  import fma16_pkg::*;

  state_t            state_reg, state_next;
  logic [SUM_W-1:0]  sum_reg, sum_next;
  logic signed [7:0] exp_reg, exp_next;
  logic              sticky_reg, sticky_next;
  logic              sign_reg, sign_next;
  rmode_t            rmode_reg, rmode_next;
  logic [15:0]       result_reg, result_next;
  logic [2:0]        flags_reg, flags_next;
  logic [15:0]       rp_result;
  logic [2:0]        rp_flags;

  fma16_round_pack #(.BIAS(BIAS)) u_round_pack (
    .sum       (sum_reg),
    .sign      (sign_reg),
    .exp       (exp_reg),
    .sticky    (sticky_reg),
    .roundmode (rmode_reg),
    .result    (rp_result),
    .flags     (rp_flags)
  );

  assign in_ready  = (state_reg == IDLE) && !reset;
  assign out_valid = (state_reg == HOLD);
  assign result    = result_reg;
  assign flags     = flags_reg;

  always_comb begin
    state_next  = state_reg;
    sum_next    = sum_reg;
    exp_next    = exp_reg;
    sticky_next = sticky_reg;
    sign_next   = sign_reg;
    rmode_next  = rmode_reg;
    result_next = result_reg;
    flags_next  = flags_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sum_next    = sum;
          exp_next    = {exp[6], exp};
          sticky_next = sticky;
          sign_next   = sign;
          rmode_next  = rmode_t'(roundmode);
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // Carry-out and underflow both move right; bits falling off feed sticky.
        if (sum_reg == '0 && !sticky_reg) begin
          state_next = ROUND;
        end else if (sum_reg[SUM_W-1] || exp_reg < 8'sd1) begin
          sum_next    = sum_reg >> 1;
          exp_next    = exp_reg + 8'sd1;
          sticky_next = sticky_reg | sum_reg[0];
        end else if (!sum_reg[SUM_W-2] && exp_reg > 8'sd1) begin
          sum_next = sum_reg << 1;
          exp_next = exp_reg - 8'sd1;
        end else begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        result_next = rp_result;
        flags_next  = rp_flags;
        state_next  = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      sum_reg    <= '0;
      exp_reg    <= '0;
      sticky_reg <= 1'b0;
      sign_reg   <= 1'b0;
      rmode_reg  <= RZ;
      result_reg <= 16'h0000;
      flags_reg  <= 3'b000;
    end else begin
      state_reg  <= state_next;
      sum_reg    <= sum_next;
      exp_reg    <= exp_next;
      sticky_reg <= sticky_next;
      sign_reg   <= sign_next;
      rmode_reg  <= rmode_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

endmodule

// File: tb/tb_fma16_normround_seq.sv
// Scoreboard bench for fma16_normround_seq: expected results are queued at
// drive time and popped when out_valid appears.
module tb_fma16_normround_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] sum_i;
  logic        sign_i;
  logic [6:0]  exp_i;
  logic        sticky_i;
  logic [1:0]  roundmode_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  flags;

  typedef struct {
    logic [15:0] result;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   op_idx = 0;

  localparam logic [1:0] M_RZ = 2'b00, M_RNE = 2'b01, M_RM = 2'b10, M_RP = 2'b11;

  fma16_normround_seq #(.SUM_W(23), .BIAS(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum_i),
    .sign      (sign_i),
    .exp       (exp_i),
    .sticky    (sticky_i),
    .roundmode (roundmode_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL [op %0d] %s: got %0h want %0h", op_idx, tag, got, want);
    end
  endtask

  task automatic drive_in(input logic [22:0] s, input logic sg, input int e,
                          input logic st, input logic [1:0] rm);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_value("accept_ready", 32'(in_ready), 32'd1);
    sum_i       = s;
    sign_i      = sg;
    exp_i       = 7'(e);
    sticky_i    = st;
    roundmode_i = rm;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; the DUT must ignore them.
    in_valid    = 1'b0;
    sum_i       = 23'($urandom);
    sign_i      = ~sg;
    exp_i       = 7'($urandom);
    sticky_i    = ~st;
    roundmode_i = ~rm;
  endtask

  task automatic run_op(input logic [22:0] s, input logic sg, input int e, input logic st,
                        input logic [1:0] rm, input logic [15:0] want_res,
                        input logic [2:0] want_flags, input int want_lat, input int hold);
    exp_t want;
    exp_t ref_v;
    int   n;
    want.result = want_res;
    want.flags  = want_flags;
    want.lat    = want_lat;
    sb_q.push_back(want);
    out_ready = (hold == 0);
    drive_in(s, sg, e, st, rm);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ref_v = sb_q.pop_front();
    op_idx++;
    $display("op %0d: sum=%06h sign=%0d exp=%0d sticky=%0d rm=%0d -> result=%04h flags=%03b latency=%0d",
             op_idx, s, sg, e, st, rm, result, flags, n);
    check_value("out_valid", 32'(out_valid), 32'd1);
    check_value("result", 32'(result), 32'(ref_v.result));
    check_value("flags", 32'(flags), 32'(ref_v.flags));
    check_value("latency", 32'(n), 32'(ref_v.lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_value("bp_valid", 32'(out_valid), 32'd1);
      check_value("bp_result", 32'(result), 32'(ref_v.result));
      check_value("bp_flags", 32'(flags), 32'(ref_v.flags));
      check_value("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("release_valid", 32'(out_valid), 32'd0);
    check_value("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    sum_i       = '0;
    sign_i      = 1'b0;
    exp_i       = '0;
    sticky_i    = 1'b0;
    roundmode_i = M_RZ;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_in_ready", 32'(in_ready), 32'd0);
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_result", 32'(result), 32'h0);
    check_value("rst_flags", 32'(flags), 32'h0);
    reset = 1'b0;
    #1;
    check_value("post_rst_in_ready", 32'(in_ready), 32'd1);

    //      sum        sg    exp  st    rm      result    flags   lat hold
    run_op(23'h200000, 1'b0,  15, 1'b0, M_RNE, 16'h3C00, 3'b000,  3, 0);
    run_op(23'h400000, 1'b0,  15, 1'b0, M_RNE, 16'h4000, 3'b000,  4, 0);
    run_op(23'h000800, 1'b0,  15, 1'b0, M_RNE, 16'h1400, 3'b000, 13, 0);
    run_op(23'h200000, 1'b0,  -2, 1'b0, M_RNE, 16'h0080, 3'b000,  6, 0);
    run_op(23'h3FFC00, 1'b0,  30, 1'b0, M_RNE, 16'h7C00, 3'b101,  3, 0);
    run_op(23'h3FFC00, 1'b0,  30, 1'b0, M_RZ,  16'h7BFF, 3'b001,  3, 0);
    run_op(23'h3FFC00, 1'b1,  30, 1'b0, M_RM,  16'hFC00, 3'b101,  3, 0);
    run_op(23'h3FFC00, 1'b0,  30, 1'b0, M_RP,  16'h7C00, 3'b101,  3, 0);
    run_op(23'h3FFC00, 1'b1,  30, 1'b0, M_RP,  16'hFBFF, 3'b001,  3, 0);
    run_op(23'h3FFC00, 1'b0,  30, 1'b0, M_RM,  16'h7BFF, 3'b001,  3, 0);
    run_op(23'h200000, 1'b0,  40, 1'b0, M_RZ,  16'h7BFF, 3'b101,  3, 0);
    run_op(23'h200000, 1'b0,  31, 1'b0, M_RNE, 16'h7C00, 3'b101,  3, 0);
    run_op(23'h200000, 1'b0,  30, 1'b0, M_RNE, 16'h7800, 3'b000,  3, 0);
    run_op(23'h000000, 1'b1,  15, 1'b0, M_RNE, 16'h8000, 3'b000,  3, 0);
    run_op(23'h000000, 1'b0,  15, 1'b1, M_RP,  16'h0001, 3'b011, 17, 0);
    run_op(23'h200001, 1'b0,  15, 1'b0, M_RP,  16'h3C01, 3'b001,  3, 0);
    run_op(23'h200400, 1'b0,  15, 1'b0, M_RNE, 16'h3C00, 3'b001,  3, 0);
    run_op(23'h200C00, 1'b0,  15, 1'b0, M_RNE, 16'h3C02, 3'b001,  3, 0);
    run_op(23'h200400, 1'b0,   0, 1'b0, M_RZ,  16'h0200, 3'b011,  4, 0);
    run_op(23'h1FFC00, 1'b0,   1, 1'b0, M_RNE, 16'h0400, 3'b011,  3, 0);
    run_op(23'h400001, 1'b0,  15, 1'b0, M_RZ,  16'h4000, 3'b001,  4, 0);
    run_op(23'h200000, 1'b1,  15, 1'b0, M_RNE, 16'hBC00, 3'b000,  3, 5);

    // Reset while normalizing: the operation vanishes without an output.
    op_idx++;
    out_ready = 1'b1;
    drive_in(23'h000800, 1'b0, 15, 1'b0, M_RNE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_value("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_value("abort_in_ready_after", 32'(in_ready), 32'd1);
    check_value("abort_result", 32'(result), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check_value("abort_no_out", 32'(seen), 32'd0);
    $display("op %0d: reset during SHIFT, out_valid seen=%0d", op_idx, seen);

    run_op(23'h400000, 1'b1,  15, 1'b0, M_RZ,  16'hC000, 3'b000,  4, 0);

    check_value("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
